// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types: address/data widths, FSM states, response record
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        data_t rdata;
        logic  err;
        logic  timeout;
    } apb_resp_t;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with wait-state timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic  PCLK,
    input  logic  PRESETn,

    input  logic  cmd_valid,
    output logic  cmd_ready,
    input  logic  cmd_write,
    input  addr_t cmd_addr,
    input  data_t cmd_wdata,

    output logic  resp_valid,
    input  logic  resp_ready,
    output data_t resp_rdata,
    output logic  resp_err,
    output logic  resp_timeout,

    output logic  PSEL,
    output logic  PENABLE,
    output logic  PWRITE,
    output addr_t PADDR,
    output data_t PWDATA,
    input  data_t PRDATA,
    input  logic  PREADY,
    input  logic  PSLVERR
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    apb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pwrite_q, pwrite_d;
    addr_t            paddr_q, paddr_d;
    data_t            pwdata_q, pwdata_d;
    logic             resp_valid_q, resp_valid_d;
    apb_resp_t        resp_q, resp_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    // Gating with PRESETn keeps the handshake closed while reset is asserted.
    assign cmd_ready = (state_q == IDLE) && !resp_valid_q && PRESETn;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = resp_valid_q && !resp_ready;
        resp_d       = resp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready completer wins even in the last permitted wait cycle.
                if (PREADY) begin
                    resp_d.rdata   = pwrite_q ? '0 : PRDATA;
                    resp_d.err     = PSLVERR;
                    resp_d.timeout = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_d.rdata   = '0;
                    resp_d.err     = 1'b1;
                    resp_d.timeout = 1'b1;
                    resp_valid_d   = 1'b1;
                    state_d        = IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PSEL         = (state_q != IDLE);
    assign PENABLE      = (state_q == ACCESS);
    assign PWRITE       = pwrite_q;
    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_q.rdata;
    assign resp_err     = resp_q.err;
    assign resp_timeout = resp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized bench for apb_master with memory-backed completer and reference model
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO        = 16;
    localparam int MEM_DEPTH = 1024;

    logic  PCLK = 1'b0;
    logic  PRESETn = 1'b0;
    logic  cmd_valid = 1'b0, cmd_write = 1'b0;
    addr_t cmd_addr = '0;
    data_t cmd_wdata = '0;
    logic  cmd_ready;
    logic  resp_valid, resp_err, resp_timeout;
    logic  resp_ready = 1'b0;
    data_t resp_rdata;
    logic  PSEL, PENABLE, PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    data_t PRDATA = '0;
    logic  PREADY = 1'b0, PSLVERR = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int total = 0;
    int bad   = 0;

    data_t ref_mem  [MEM_DEPTH];
    data_t comp_mem [MEM_DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transfer: the completer answers in ACCESS cycle waits+1 (never if waits >= TO).
    task automatic xfer(input logic wr, input addr_t a, input data_t wd, input int waits);
        logic  oob, to;
        int    exp_acc, acc, hold;
        data_t exp_rd, seen_rd;
        bit    ended;
        oob     = (a >= MEM_DEPTH);
        to      = (waits >= TO);
        exp_acc = to ? TO : waits + 1;
        exp_rd  = (to || wr || oob) ? '0 : ref_mem[a[9:0]];
        if (wr && !to && !oob) ref_mem[a[9:0]] = wd;

        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

        @(negedge PCLK);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", PADDR, a);
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("setup_pwdata", PWDATA, wd);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_wdata = $urandom;

        acc = 0; ended = 0;
        for (int g = 0; g < 40 && !ended; g++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                acc++;
                chk("access_paddr", PADDR, a);
                chk("access_pwrite", 32'(PWRITE), 32'(wr));
                PREADY  = (acc == waits + 1);
                PSLVERR = oob;
                PRDATA  = (!wr && !oob) ? comp_mem[a[9:0]] : '0;
                if (PREADY && wr && !oob) comp_mem[a[9:0]] = PWDATA;
            end else begin
                ended = 1;
            end
        end
        if (!ended) chk("xfer_bound", 32'd0, 32'd1);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom; cmd_valid = 1'b0;

        chk("access_cycles", 32'(acc), 32'(exp_acc));
        chk("psel_after", 32'(PSEL), 32'd0);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(to | oob));
        chk("resp_timeout", 32'(resp_timeout), 32'(to));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        seen_rd = resp_rdata;

        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            @(negedge PCLK);
            PRDATA = $urandom;
            chk("resp_hold_valid", 32'(resp_valid), 32'd1);
            chk("resp_hold_rdata", resp_rdata, seen_rd);
        end
        resp_ready = 1'b1;
        #1 chk("cmd_ready_handshake", 32'(cmd_ready), 32'd0);
        @(negedge PCLK);
        resp_ready = 1'b0;
        chk("resp_drop", 32'(resp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        data_t v;
        int    r, w;
        addr_t a;
        bit    seen;

        for (int i = 0; i < MEM_DEPTH; i++) begin
            v = $urandom;
            ref_mem[i]  = v;
            comp_mem[i] = v;
        end
        ref_mem[32'h30]  = 32'h12345678;
        comp_mem[32'h30] = 32'h12345678;

        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        #1 chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);
        xfer(1'b0, 32'h10, 32'h0, 0);
        xfer(1'b0, 32'h30, 32'h0, 3);
        xfer(1'b0, 32'd1024, 32'h0, 0);
        xfer(1'b0, 32'h40, 32'h0, 1000);
        xfer(1'b0, 32'h44, 32'h0, TO - 1);
        xfer(1'b1, 32'h48, 32'hA5A5_0001, TO - 2);

        // Reset pulse in the middle of ACCESS abandons the transfer.
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_rst_access", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel", 32'(PSEL), 32'd0);
        chk("midrst_penable", 32'(PENABLE), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_paddr", PADDR, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            if (resp_valid || PSEL) seen = 1;
        end
        chk("no_resp_after_rst", 32'(seen), 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 4);
            else if (r == 7) w = TO - 1;
            else if (r == 8) w = 30;
            else             w = $urandom_range(5, TO - 2);
            if ($urandom_range(0, 7) == 0) a = 32'd1024 + $urandom_range(0, 100);
            else                           a = $urandom_range(0, MEM_DEPTH - 1);
            xfer(1'($urandom_range(0, 1)), a, $urandom, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles waited for PREADY before the transfer aborts.
REQ-002 PCLK  input  1  the block's single clock; all state updates on its rising edge.
REQ-003 PRESETn  input  1  reset; asynchronous and active-low.
REQ-004 cmd_valid  input  1  a command is offered.
REQ-005 cmd_ready  output  1  block accepts the command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  addr_t  transfer address.
REQ-008 cmd_wdata  input  data_t  write data; ignored for reads.
REQ-009 resp_valid  output  1  response is held for the requester.
REQ-010 resp_ready  input  1  requester consumes the response.
REQ-011 resp_rdata  output  data_t  read data; 0 for writes and for timeouts.
REQ-012 resp_err  output  1  PSLVERR was sampled, or the transfer timed out.
REQ-013 resp_timeout  output  1  the transfer aborted on timeout.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB requester controls.
REQ-015 PADDR  output  addr_t;  PWDATA  output  data_t  APB address and write data.
REQ-016 PRDATA  input  data_t;  PREADY, PSLVERR  input  1 each  APB completer returns.

Function
REQ-017 The state machine SHALL use the states IDLE, SETUP and ACCESS.
- IDLE->SETUP on cmd_valid && cmd_ready.
- SETUP->ACCESS unconditionally after 1 cycle.
- ACCESS->IDLE when PREADY=1 or on timeout.
REQ-018 cmd_ready SHALL equal (state==IDLE && !resp_valid && PRESETn), combinationally.
REQ-019 On accept, the block SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and hold them stable through SETUP and ACCESS.
REQ-020 SETUP SHALL drive PSEL=1 and PENABLE=0; ACCESS SHALL drive PSEL=1 and PENABLE=1; IDLE SHALL drive PSEL=0 and PENABLE=0.
REQ-021 The block SHALL sample PRDATA, PREADY and PSLVERR only in ACCESS, at a rising edge.
REQ-022 Latency with zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, resp_valid=1 in N+3.
REQ-023 A wait-state counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
- Counter width: $clog2(TIMEOUT_CYCLES+1).
- Counter saturates; it never wraps.
REQ-024 If the counter reaches TIMEOUT_CYCLES-1 and PREADY=0 in that cycle, the block SHALL abort to IDLE with resp_err=1, resp_timeout=1 and resp_rdata=0.
REQ-025 PREADY=1 in the final permitted cycle SHALL complete the transfer normally; normal completion takes priority over timeout.
REQ-026 On completion, resp_rdata SHALL take PRDATA for reads and 0 for writes; resp_err SHALL take PSLVERR.
REQ-027 resp_valid and all resp_* outputs SHALL hold stable until resp_valid && resp_ready; resp_valid deasserts on the following edge.
REQ-028 No new command SHALL be accepted while resp_valid=1, including in the cycle resp_ready is asserted; at most one transfer is outstanding.
REQ-029 cmd_valid SHALL have no effect outside IDLE.

Reset
REQ-030 PRESETn low SHALL immediately force state=IDLE and clear the counter.
REQ-031 PRESETn low SHALL immediately force PSEL, PENABLE, PWRITE, PADDR, PWDATA, resp_valid, resp_rdata, resp_err, resp_timeout and cmd_ready to 0.
REQ-032 Reset in SETUP or ACCESS SHALL abandon the transfer with no response produced after reset release.

Structure
REQ-033 The block SHALL import apb_pkg and reuse its apb_state_t, addr_t and data_t.
REQ-034 A new apb_resp_t packed struct {rdata, err, timeout} SHALL be added to apb_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-036 Write 0x10 <- 0xDEADBEEF to the memory-backed completer -> APB write seen at cycles N+1/N+2; resp_valid at N+3 with err=0; a read of 0x10 then returns 0xDEADBEEF.
REQ-037 Read with PREADY held low 3 cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles; PADDR and PENABLE are stable throughout; resp_rdata=0x12345678.
REQ-038 Read of address 1024 (beyond MEM_DEPTH) -> resp_err=1, resp_timeout=0.
REQ-039 Completer that never asserts PREADY, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles; resp_err=1, resp_timeout=1, resp_rdata=0.
REQ-040 PREADY=1 exactly in ACCESS cycle 16 -> normal completion; resp_timeout=0.
REQ-041 PRESETn pulsed low mid-ACCESS -> PSEL and PENABLE drop the same cycle; no resp_valid follows; the next command is accepted normally.
